// File: rtl/key_pkg.sv
// Shared constants and types for the time-shared key debounce controller.
// Keys are active-low: a released key idles at 1.
package key_pkg;

  localparam logic KEY_PRESSED  = 1'b0;
  localparam logic KEY_RELEASED = 1'b1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } fsm_state_t;

  // Width of a counter that must hold values 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer, one independent chain per bit. Resets to the
// released level so that a power-up reset never looks like a press.
module key_sync
  import key_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_reg;
  logic [W-1:0] sync_reg;

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_bit
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          meta_reg[gi] <= KEY_RELEASED;
          sync_reg[gi] <= KEY_RELEASED;
        end else begin
          meta_reg[gi] <= d[gi];
          sync_reg[gi] <= meta_reg[gi];
        end
      end
    end
  endgenerate

  assign q = sync_reg;

endmodule

// File: rtl/key_debounce_arb.sv
// Debounces KEY_NUM active-low keys with one shared stability counter,
// handed between keys by a round-robin arbiter; counts accepted presses.
module key_debounce_arb
  import key_pkg::*;
#(
  parameter int KEY_NUM     = 4,
  parameter int COUNTER_NUM = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KEY_NUM-1:0] key_in,
  input  logic               sum_clr,
  output logic [KEY_NUM-1:0] key_state,
  output logic [KEY_NUM-1:0] key_press,
  output logic [3:0]         sum,
  output logic               busy
);

  localparam int CW = cnt_width(COUNTER_NUM);
  localparam int IW = $clog2(KEY_NUM);
  localparam logic [CW-1:0] CNT_LAST = CW'(COUNTER_NUM - 1);
  localparam logic [IW-1:0] RR_INIT  = IW'(KEY_NUM - 1);

  logic [KEY_NUM-1:0] ks;
  logic [KEY_NUM-1:0] pending;

  fsm_state_t         state_reg, state_next;
  logic [IW-1:0]      sel_reg, sel_next;
  logic               target_reg, target_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic [IW-1:0]      rr_reg, rr_next;
  logic [KEY_NUM-1:0] key_state_reg, key_state_next;
  logic [KEY_NUM-1:0] key_press_reg, key_press_next;
  logic [3:0]         sum_reg, sum_next;

  logic               grant_found;
  logic [IW-1:0]      grant_idx;
  logic [IW-1:0]      cand;
  logic               commit_press;

  key_sync #(.W(KEY_NUM)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (key_in),
    .q     (ks)
  );

  assign pending = ks ^ key_state_reg;

  // Scan from the farthest offset down so the nearest key after rr wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = KEY_NUM; k >= 1; k--) begin
      cand = IW'((int'(rr_reg) + k) % KEY_NUM);
      if (pending[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    sel_next       = sel_reg;
    target_next    = target_reg;
    cnt_next       = cnt_reg;
    rr_next        = rr_reg;
    key_state_next = key_state_reg;
    key_press_next = '0;
    sum_next       = sum_reg;
    commit_press   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (grant_found) begin
          sel_next    = grant_idx;
          target_next = ks[grant_idx];
          cnt_next    = '0;
          rr_next     = grant_idx;
          state_next  = COUNT;
        end
      end
      COUNT: begin
        if (ks[sel_reg] != target_reg) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else if (cnt_reg == CNT_LAST) begin
          key_state_next[sel_reg] = target_reg;
          if (target_reg == KEY_PRESSED) begin
            key_press_next[sel_reg] = 1'b1;
            commit_press            = 1'b1;
          end
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    // A clear on the commit cycle wins over the increment.
    if (sum_clr) begin
      sum_next = '0;
    end else if (commit_press) begin
      sum_next = sum_reg + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      sel_reg       <= '0;
      target_reg    <= KEY_RELEASED;
      cnt_reg       <= '0;
      rr_reg        <= RR_INIT;
      key_state_reg <= '1;
      key_press_reg <= '0;
      sum_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      sel_reg       <= sel_next;
      target_reg    <= target_next;
      cnt_reg       <= cnt_next;
      rr_reg        <= rr_next;
      key_state_reg <= key_state_next;
      key_press_reg <= key_press_next;
      sum_reg       <= sum_next;
    end
  end

  assign key_state = key_state_reg;
  assign key_press = key_press_reg;
  assign sum       = sum_reg;
  assign busy      = (state_reg == COUNT);

endmodule

// File: tb/tb_key_debounce_arb.sv
// Scoreboard bench for key_debounce_arb: expected presses are queued by the
// stimulus and matched by a negedge monitor whenever key_press fires.
module tb_key_debounce_arb;

  localparam int KEY_NUM     = 4;
  localparam int COUNTER_NUM = 5;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [KEY_NUM-1:0] key_in;
  logic               sum_clr;
  logic [KEY_NUM-1:0] key_state;
  logic [KEY_NUM-1:0] key_press;
  logic [3:0]         sum;
  logic               busy;

  key_debounce_arb #(.KEY_NUM(KEY_NUM), .COUNTER_NUM(COUNTER_NUM)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_in    (key_in),
    .sum_clr   (sum_clr),
    .key_state (key_state),
    .key_press (key_press),
    .sum       (sum),
    .busy      (busy)
  );

  always #10 clk = ~clk;

  typedef struct {
    int idx;
    int sum;
    int gap;   // expected cycles since previous press, 0 = don't care
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_cyc = 0;
  int   exp_sum = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end else begin
      $display("check %s = %0h ok", name, act);
    end
  endtask

  // Monitor: every key_press pulse must match the head of the queue.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (key_press != '0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_press actual=%b expected=none", key_press);
      end else begin
        e = exp_q.pop_front();
        chk("press_vec", 32'(key_press), 32'(1 << e.idx));
        chk("press_sum", 32'(sum), 32'(e.sum));
        chk("press_state", 32'(key_state[e.idx]), 32'd0);
        if (e.gap != 0) chk("press_gap", 32'(cyc - last_cyc), 32'(e.gap));
      end
      last_cyc = cyc;
    end
  end

  // Inputs are always driven 2 ns after a rising edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic expect_press(input int idx, input int gap);
    exp_sum = (exp_sum + 1) % 16;
    exp_q.push_back('{idx: idx, sum: exp_sum, gap: gap});
  endtask

  // Count edges from the current drive point until key_press[idx] rises.
  task automatic measure(input int idx, input int exp_lat, input string name);
    int lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (key_press[idx]) begin
        lat = c;
        break;
      end
    end
    chk(name, 32'(lat), 32'(exp_lat));
    #1;
  endtask

  task automatic tap(input int idx);
    expect_press(idx, 0);
    key_in[idx] = 1'b0;
    step(12);
    key_in[idx] = 1'b1;
    step(12);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    exp_sum = 0;
    step(1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    key_in  = '1;
    sum_clr = 1'b0;
    step(3);
    chk("rst_key_state", 32'(key_state), 32'hF);
    chk("rst_key_press", 32'(key_press), 32'h0);
    chk("rst_sum", 32'(sum), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    step(2);

    // Single press on key 0: pulse on edge 3+COUNTER_NUM.
    expect_press(0, 0);
    key_in[0] = 1'b0;
    measure(0, 8, "single_latency");
    step(6);
    chk("single_state", 32'(key_state), 32'hE);
    chk("single_busy", 32'(busy), 32'h0);
    key_in[0] = 1'b1;
    step(15);
    chk("release_state", 32'(key_state), 32'hF);
    chk("release_sum", 32'(sum), 32'd1);

    // Bounce on key 1: first attempt aborts, second is accepted.
    key_in[1] = 1'b0;
    step(3);
    key_in[1] = 1'b1;
    step(2);
    expect_press(1, 0);
    key_in[1] = 1'b0;
    measure(1, 8, "bounce_latency");
    step(6);
    key_in[1] = 1'b1;
    step(12);
    chk("bounce_sum", 32'(sum), 32'd2);

    // Short glitch on key 3 while key 0 is being debounced.
    expect_press(0, 0);
    key_in[0] = 1'b0;
    step(4);
    key_in[3] = 1'b0;
    step(2);
    key_in[3] = 1'b1;
    step(10);
    chk("glitch_state", 32'(key_state), 32'hE);
    key_in[0] = 1'b1;
    step(12);

    // Reset in the middle of debouncing key 1.
    key_in[1] = 1'b0;
    step(5);
    chk("mid_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_state", 32'(key_state), 32'hF);
    chk("mid_rst_sum", 32'(sum), 32'h0);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_press", 32'(key_press), 32'h0);
    #1;
    exp_sum = 0;
    step(2);
    rst_n = 1'b1;
    expect_press(1, 0);
    measure(1, 8, "post_rst_latency");
    step(4);
    key_in[1] = 1'b1;
    step(12);

    // All keys together after a fresh reset: 0,1,2,3 six cycles apart.
    do_reset();
    expect_press(0, 0);
    expect_press(1, 6);
    expect_press(2, 6);
    expect_press(3, 6);
    key_in = '0;
    step(30);
    chk("simul_sum", 32'(sum), 32'd4);
    chk("simul_state", 32'(key_state), 32'h0);
    key_in = '1;
    step(30);
    chk("simul_release", 32'(key_state), 32'hF);

    // Serve key 1 alone, then all together: order rotates to 2,3,0,1.
    tap(1);
    expect_press(2, 0);
    expect_press(3, 6);
    expect_press(0, 6);
    expect_press(1, 6);
    key_in = '0;
    step(30);
    chk("rot_sum", 32'(sum), 32'd9);
    key_in = '1;
    step(30);

    // Clear, then 17 presses of key 2 wrap the count to 1.
    sum_clr = 1'b1;
    step(1);
    sum_clr = 1'b0;
    exp_sum = 0;
    chk("clr_sum", 32'(sum), 32'd0);
    for (int n = 0; n < 17; n++) tap(2);
    chk("wrap_sum", 32'(sum), 32'd1);

    // Clear coinciding with the commit of an 18th press.
    exp_q.push_back('{idx: 2, sum: 0, gap: 0});
    exp_sum = 0;
    key_in[2] = 1'b0;
    step(7);
    sum_clr = 1'b1;
    step(1);
    sum_clr = 1'b0;
    chk("clr_commit_sum", 32'(sum), 32'd0);
    chk("clr_commit_state", 32'(key_state), 32'hB);
    key_in[2] = 1'b1;
    step(12);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
